// File: rtl/utopia_rx_merge.sv
// Multi-port Utopia receive front end: polls ports round-robin, assembles
// cells into a ping-pong buffer and emits them as one tagged byte stream.
module utopia_rx_merge #(
  parameter int NumRx = 4,
  parameter int CellBytes = 53,
  parameter int DataW = 8,
  parameter int CntW = 8,
  localparam int PW = $clog2(NumRx)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NumRx*DataW-1:0] rx_data,
  input  logic [NumRx-1:0]      rx_soc,
  input  logic [NumRx-1:0]      rx_clav,
  output logic [NumRx-1:0]      rx_en,
  output logic [DataW-1:0]      out_data,
  output logic                  out_soc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PW-1:0]         out_port,
  output logic [NumRx*CntW-1:0] err_cnt,
  output logic [15:0]           cell_cnt
);

  localparam int IW = $clog2(CellBytes);
  localparam logic [IW-1:0] LastIdx = IW'(CellBytes - 1);
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic {C_IDLE, C_COLLECT} c_state_e;
  typedef enum logic {E_IDLE, E_SEND} e_state_e;

  c_state_e c_state_q, c_state_d;
  e_state_e e_state_q, e_state_d;

  logic [PW-1:0] sel_q, sel_d;
  logic [PW-1:0] last_grant_q, last_grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          fill_q, fill_d;
  logic [NumRx-1:0] rx_en_q, rx_en_d;
  logic [NumRx-1:0][CntW-1:0] err_q, err_d;
  logic [1:0]    full_q, full_d;
  logic [1:0][PW-1:0] tag_q, tag_d;
  logic          ebuf_q, ebuf_d;
  logic [IW-1:0] eidx_q, eidx_d;
  logic [15:0]   cell_cnt_q, cell_cnt_d;

  logic [DataW-1:0] mem_q [2][CellBytes];
  logic          mem_we;
  logic [IW-1:0] mem_idx;

  logic [NumRx-1:0][DataW-1:0] rx_bytes;
  logic [DataW-1:0] cur_byte;
  logic          cur_soc;
  logic          grant_hit, grant_vld;
  logic [PW-1:0] grant_port;
  logic          acc, bad_lead, resync, done, rel_port;
  logic          e_fire, e_last;

  assign rx_bytes = rx_data;
  assign cur_byte = rx_bytes[sel_q];
  assign cur_soc  = rx_soc[sel_q];

  // First requesting port after last_grant wins; scan from the far end
  // so the nearest candidate overwrites the others.
  always_comb begin
    grant_hit  = 1'b0;
    grant_port = last_grant_q;
    for (int k = NumRx; k >= 1; k--) begin
      if (rx_clav[PW'((int'(last_grant_q) + k) % NumRx)]) begin
        grant_hit  = 1'b1;
        grant_port = PW'((int'(last_grant_q) + k) % NumRx);
      end
    end
  end

  assign grant_vld = (c_state_q == C_IDLE) && !(&full_q) && grant_hit;
  assign acc       = (c_state_q == C_COLLECT) && rx_en_q[sel_q] && rx_clav[sel_q];
  assign bad_lead  = acc && (idx_q == '0) && !cur_soc;
  assign resync    = acc && (idx_q != '0) && cur_soc;
  assign done      = acc && (idx_q == LastIdx) && !cur_soc;
  assign rel_port  = (c_state_q == C_COLLECT) && (idx_q == '0) && !rx_clav[sel_q];

  assign e_fire = (e_state_q == E_SEND) && out_ready;
  assign e_last = e_fire && (eidx_q == LastIdx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_state_q    <= C_IDLE;
      e_state_q    <= E_IDLE;
      sel_q        <= '0;
      last_grant_q <= PW'(NumRx - 1);
      idx_q        <= '0;
      fill_q       <= 1'b0;
      rx_en_q      <= '0;
      err_q        <= '0;
      full_q       <= '0;
      tag_q        <= '0;
      ebuf_q       <= 1'b0;
      eidx_q       <= '0;
      cell_cnt_q   <= '0;
    end else begin
      c_state_q    <= c_state_d;
      e_state_q    <= e_state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      idx_q        <= idx_d;
      fill_q       <= fill_d;
      rx_en_q      <= rx_en_d;
      err_q        <= err_d;
      full_q       <= full_d;
      tag_q        <= tag_d;
      ebuf_q       <= ebuf_d;
      eidx_q       <= eidx_d;
      cell_cnt_q   <= cell_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[fill_q][mem_idx] <= cur_byte;
  end

  always_comb begin
    c_state_d = c_state_q;
    unique case (c_state_q)
      C_IDLE:    if (grant_vld) c_state_d = C_COLLECT;
      C_COLLECT: if (rel_port || done) c_state_d = C_IDLE;
    endcase
    e_state_d = e_state_q;
    unique case (e_state_q)
      E_IDLE: if (|full_q) e_state_d = E_SEND;
      E_SEND: if (e_last && !full_q[~ebuf_q]) e_state_d = E_IDLE;
    endcase
  end

  always_comb begin
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    idx_d        = idx_q;
    fill_d       = fill_q;
    rx_en_d      = rx_en_q;
    err_d        = err_q;
    full_d       = full_q;
    tag_d        = tag_q;
    ebuf_d       = ebuf_q;
    eidx_d       = eidx_q;
    cell_cnt_d   = cell_cnt_q;
    mem_we       = 1'b0;
    mem_idx      = idx_q;

    if (grant_vld) begin
      sel_d   = grant_port;
      idx_d   = '0;
      fill_d  = full_q[0];
      rx_en_d = '0;
      rx_en_d[grant_port] = 1'b1;
    end

    if ((bad_lead || resync) && (err_q[sel_q] != CntMax))
      err_d[sel_q] = err_q[sel_q] + 1'b1;

    // A mid-cell SOC restarts the cell with this byte as byte 0.
    if (acc && !bad_lead) begin
      mem_we  = 1'b1;
      mem_idx = resync ? '0 : idx_q;
      idx_d   = resync ? IW'(1) : idx_q + 1'b1;
    end

    if (done) begin
      idx_d          = '0;
      full_d[fill_q] = 1'b1;
      tag_d[fill_q]  = sel_q;
      last_grant_d   = sel_q;
      rx_en_d        = '0;
    end

    if (rel_port) rx_en_d = '0;

    if ((e_state_q == E_IDLE) && (|full_q)) begin
      ebuf_d = ~full_q[0];
      eidx_d = '0;
    end

    if (e_fire) eidx_d = eidx_q + 1'b1;

    if (e_last) begin
      eidx_d         = '0;
      full_d[ebuf_q] = 1'b0;
      cell_cnt_d     = cell_cnt_q + 16'd1;
      ebuf_d         = ~ebuf_q;
    end
  end

  assign rx_en     = rx_en_q;
  assign err_cnt   = err_q;
  assign cell_cnt  = cell_cnt_q;
  assign out_valid = (e_state_q == E_SEND);
  assign out_soc   = out_valid && (eidx_q == '0);
  assign out_data  = out_valid ? mem_q[ebuf_q][eidx_q] : '0;
  assign out_port  = out_valid ? tag_q[ebuf_q] : '0;

endmodule
